uart_rx_frame_ctrl: RTL and testbench

Parametrised next-generation UART receive controller. It merges the frame FSM, the oversampling edge counter, the bit counter, 3-sample majority voting, the deserializer and the start/parity/stop checkers into one block. It adds runtime data width up to DATA_WIDTH, even/odd parity, 1 or 2 stop bits, and back-to-back frame support. It sits between the synchronised RX pin and the system-side RX data consumer.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_frame_ctrl_if.sv | 19 +
 rtl/uart_rx_sampler.sv | 51 +++++
 rtl/uart_rx_frame_ctrl.sv | 158 +++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared state encoding and constants for the UART receive controller.
// The BRK state exists only when UART_RX_BREAK_DET_EN is defined.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
`ifdef UART_RX_BREAK_DET_EN
        ST_DONE   = 3'd5,
        ST_BRK    = 3'd6
`else
        ST_DONE   = 3'd5
`endif
    } rx_state_e;

    localparam int MIN_PRESCALE   = 8;
    localparam int MIN_DATA_LEN   = 5;
    localparam int SAMP_OFS_EARLY = -1;
    localparam int SAMP_OFS_MID   = 0;
    localparam int SAMP_OFS_LATE  = 1;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Receive-side result bus: data word, valid strobe and per-frame error flags.
// Break is carried only when UART_RX_BREAK_DET_EN is defined.
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_valid;
    logic                  Par_err;
    logic                  Stop_err;
`ifdef UART_RX_BREAK_DET_EN
    logic                  Break;

    modport master (output P_DATA, Data_valid, Par_err, Stop_err, Break);
    modport slave  (input  P_DATA, Data_valid, Par_err, Stop_err, Break);
`else
    modport master (output P_DATA, Data_valid, Par_err, Stop_err);
    modport slave  (input  P_DATA, Data_valid, Par_err, Stop_err);
`endif
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with three-sample majority vote around mid-bit.
// Strobes the sample point (edge P/2+1) and the last edge (edge P-1).
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  i_rx,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_clr,
    output logic                  o_sample_pt,
    output logic                  o_last_edge,
    output logic                  o_bit
);
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic                  r_samp_early;
    logic                  r_samp_mid;
    logic [PRESCALE_W-1:0] w_half;
    logic [PRESCALE_W-1:0] w_idx_early;
    logic [PRESCALE_W-1:0] w_idx_mid;
    logic [PRESCALE_W-1:0] w_idx_late;

    assign w_half      = i_prescale >> 1;
    assign w_idx_early = w_half + PRESCALE_W'(SAMP_OFS_EARLY);
    assign w_idx_mid   = w_half + PRESCALE_W'(SAMP_OFS_MID);
    assign w_idx_late  = w_half + PRESCALE_W'(SAMP_OFS_LATE);

    assign o_last_edge = (r_edge_cnt == i_prescale - PRESCALE_W'(1));
    assign o_sample_pt = (r_edge_cnt == w_idx_late);
    // The late sample is the live input, so the vote is ready at the sample point itself.
    assign o_bit = (r_samp_early & r_samp_mid) | (r_samp_early & i_rx) | (r_samp_mid & i_rx);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_edge_cnt   <= '0;
            r_samp_early <= 1'b1;
            r_samp_mid   <= 1'b1;
        end else begin
            if (i_clr || o_last_edge)
                r_edge_cnt <= '0;
            else
                r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
            if (r_edge_cnt == w_idx_early)
                r_samp_early <= i_rx;
            if (r_edge_cnt == w_idx_mid)
                r_samp_mid <= i_rx;
        end
    end
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start/data/parity/stop FSM, bit counter, deserializer, checkers.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [3:0]            Data_len,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    uart_rx_frame_ctrl_if.master  rx_out
);
    rx_state_e             r_state, w_next;
    logic [PRESCALE_W-1:0] r_p;
    logic [3:0]            r_len;
    logic [3:0]            r_bit_cnt;
    logic                  r_par_en, r_par_typ, r_stop2, r_stop_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid, r_par_err, r_stop_err;
    logic                  w_sample_pt, w_last_edge, w_bit, w_clr, w_start;

    function automatic logic [PRESCALE_W-1:0] norm_prescale(input logic [PRESCALE_W-1:0] p);
        logic [PRESCALE_W-1:0] even;
        even = {p[PRESCALE_W-1:1], 1'b0};
        return (even < PRESCALE_W'(MIN_PRESCALE)) ? PRESCALE_W'(MIN_PRESCALE) : even;
    endfunction

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (len < 4'(MIN_DATA_LEN)) return 4'(MIN_DATA_LEN);
        if (len > 4'(DATA_WIDTH))   return 4'(DATA_WIDTH);
        return len;
    endfunction

    assign w_start = (r_state == ST_IDLE) && !RX_IN;

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .CLK         (CLK),
        .Reset       (Reset),
        .i_rx        (RX_IN),
        .i_prescale  (r_p),
        .i_clr       (w_clr),
        .o_sample_pt (w_sample_pt),
        .o_last_edge (w_last_edge),
        .o_bit       (w_bit)
    );

`ifdef UART_RX_BREAK_DET_EN
    logic r_break, r_stop_low, w_brk_frame;
    assign w_brk_frame  = (r_shift == '0) && r_stop_low;
    assign rx_out.Break = r_break;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_break    <= 1'b0;
            r_stop_low <= 1'b0;
        end else begin
            r_break <= (r_state == ST_DONE) && w_brk_frame;
            if (r_state == ST_STOP && w_sample_pt)
                r_stop_low <= !w_bit;
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (!RX_IN) w_next = ST_START;
            ST_START:  if (w_sample_pt && w_bit) w_next = ST_IDLE;
                       else if (w_last_edge) w_next = ST_DATA;
            ST_DATA:   if (w_last_edge && r_bit_cnt == r_len - 4'd1)
                           w_next = r_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_last_edge) w_next = ST_STOP;
            ST_STOP:   if (w_sample_pt && (!r_stop2 || r_stop_idx)) w_next = ST_DONE;
`ifdef UART_RX_BREAK_DET_EN
            ST_DONE:   w_next = w_brk_frame ? ST_BRK : ST_IDLE;
            ST_BRK:    if (RX_IN && w_last_edge) w_next = ST_IDLE;
`else
            ST_DONE:   w_next = ST_IDLE;
`endif
            default:   w_next = ST_IDLE;
        endcase
    end

    // Edge counter restarts on entry to IDLE; in BRK it counts consecutive high clocks.
    always_comb begin
        w_clr = (w_next == ST_IDLE);
`ifdef UART_RX_BREAK_DET_EN
        if (w_next == ST_BRK && (r_state != ST_BRK || !RX_IN))
            w_clr = 1'b1;
`endif
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state      <= ST_IDLE;
            r_p          <= PRESCALE_W'(MIN_PRESCALE);
            r_len        <= 4'(MIN_DATA_LEN);
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_stop2      <= 1'b0;
            r_bit_cnt    <= '0;
            r_stop_idx   <= 1'b0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stop_err   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_data_valid <= 1'b0;
            if (w_start) begin
                r_p        <= norm_prescale(Prescale);
                r_len      <= clamp_len(Data_len);
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_stop2    <= STOP2;
                r_bit_cnt  <= '0;
                r_stop_idx <= 1'b0;
                r_par_err  <= 1'b0;
                r_stop_err <= 1'b0;
            end
            case (r_state)
                ST_DATA: if (w_last_edge)
                    r_bit_cnt <= (r_bit_cnt == r_len - 4'd1) ? 4'd0 : r_bit_cnt + 4'd1;
                ST_PARITY: if (w_sample_pt)
                    r_par_err <= ((^r_shift) ^ r_par_typ) != w_bit;
                ST_STOP: begin
                    if (w_sample_pt && !w_bit) r_stop_err <= 1'b1;
                    if (w_last_edge)           r_stop_idx <= 1'b1;
                end
                ST_DONE: if (!r_par_err && !r_stop_err) begin
                    r_p_data     <= r_shift;
                    r_data_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Deserializer: bit n lands at index n, so short frames stay right-aligned.
    always_ff @(posedge CLK) begin
        if (w_start)
            r_shift <= '0;
        else if (r_state == ST_DATA && w_sample_pt)
            r_shift <= r_shift | (DATA_WIDTH'(w_bit) << r_bit_cnt);
    end

    assign rx_out.P_DATA     = r_p_data;
    assign rx_out.Data_valid = r_data_valid;
    assign rx_out.Par_err    = r_par_err;
    assign rx_out.Stop_err   = r_stop_err;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed and randomized frames against a frame-level reference model of the receiver.
// Define UART_RX_BREAK_DET_EN to include the break-detection steps.
module tb_uart_rx_frame_ctrl;
    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          RX_IN;
    logic [PW-1:0] Prescale;
    logic [3:0]    Data_len;
    logic          PAR_EN, PAR_TYP, STOP2;

    uart_rx_frame_ctrl_if #(.DATA_WIDTH(DW)) rx_if ();

    uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .RX_IN    (RX_IN),
        .Prescale (Prescale),
        .Data_len (Data_len),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .STOP2    (STOP2),
        .rx_out   (rx_if)
    );

    always #5 CLK = ~CLK;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_pdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Holds RX_IN at a level for n clocks, counting Data_valid pulses seen.
    task automatic drive_level(input logic lvl, input int n, output int dv);
        dv = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (rx_if.Data_valid === 1'b1) dv++;
            RX_IN = lvl;
        end
    endtask

    // Sends one frame (P clocks per bit), then 'idle' high clocks, and checks the outcome.
    task automatic send_frame(input string tag, input logic [DW-1:0] data, input int pres,
                              input int len, input bit pen, input bit ptyp, input bit s2,
                              input bit bad_par, input bit [1:0] stops, input int spike_bit,
                              input int idle);
        int p_eff, l_eff, f, t_exp, t_end, dv_cnt, dv_t, b, brk_cnt;
        bit q[$];
        logic [DW-1:0] d;
        logic sent_par, exp_pe, exp_se, valid, pe_at, se_at;
        p_eff = pres & ~1;
        if (p_eff < 8) p_eff = 8;
        l_eff = (len < 5) ? 5 : ((len > DW) ? DW : len);
        d = data & DW'((1 << l_eff) - 1);
        sent_par = (^d) ^ ptyp ^ bad_par;
        q.push_back(1'b0);
        for (int i = 0; i < l_eff; i++) q.push_back(d[i]);
        if (pen) q.push_back(sent_par);
        q.push_back(stops[0]);
        if (s2) q.push_back(stops[1]);
        exp_pe = pen && bad_par;
        exp_se = !stops[0] || (s2 && !stops[1]);
        valid  = !exp_pe && !exp_se;
        f      = q.size() - 1;
        t_exp  = f * p_eff + p_eff / 2 + 3;
        t_end  = q.size() * p_eff + idle;
        dv_cnt = 0; dv_t = -1; brk_cnt = 0; pe_at = 1'bx; se_at = 1'bx;
        for (int t = 0; t < t_end; t++) begin
            @(negedge CLK);
            if (t > 0) begin
                if (rx_if.Data_valid === 1'b1) begin
                    dv_cnt++;
                    if (dv_cnt == 1) dv_t = t;
                end
`ifdef UART_RX_BREAK_DET_EN
                if (rx_if.Break === 1'b1) brk_cnt++;
`endif
                if (t == t_exp) begin
                    pe_at = rx_if.Par_err;
                    se_at = rx_if.Stop_err;
                end
            end
            if (t == 0) begin
                Prescale = PW'(pres); Data_len = 4'(len);
                PAR_EN = pen; PAR_TYP = ptyp; STOP2 = s2;
            end
            b = t / p_eff;
            RX_IN = (b < q.size()) ? q[b] : 1'b1;
            if (spike_bit >= 0 && b == spike_bit + 1 && (t % p_eff) == p_eff / 2)
                RX_IN = ~RX_IN;
        end
        if (valid) exp_pdata = d;
        check({tag, ".dv_count"}, dv_cnt, valid ? 1 : 0);
        if (valid) check({tag, ".dv_latency"}, dv_t, t_exp);
        check({tag, ".p_data"}, rx_if.P_DATA, exp_pdata);
        check({tag, ".par_err"}, pe_at, exp_pe);
        check({tag, ".stop_err"}, se_at, exp_se);
`ifdef UART_RX_BREAK_DET_EN
        check({tag, ".break"}, brk_cnt, (d == '0 && !(s2 ? stops[1] : stops[0])) ? 1 : 0);
`endif
        if (brk_cnt < 0) $display("unreachable");
    endtask

    initial begin
        int dv, dv2;
        logic [DW-1:0] rd;
        int pres, len, sbit;
        bit pen, ptyp, s2, badp;
        bit [1:0] stops;

        exp_pdata = '0;
        Reset = 1'b0; RX_IN = 1'b1; Prescale = 8; Data_len = 8;
        PAR_EN = 0; PAR_TYP = 0; STOP2 = 0;
        #23;
        check("reset.p_data",     rx_if.P_DATA,     0);
        check("reset.data_valid", rx_if.Data_valid, 0);
        check("reset.par_err",    rx_if.Par_err,    0);
        check("reset.stop_err",   rx_if.Stop_err,   0);
        @(negedge CLK); Reset = 1'b1;
        drive_level(1'b1, 5, dv);

        send_frame("a5",        8'hA5, 8,  8, 0, 0, 0, 0, 2'b11, -1, 16);
        send_frame("par_ok",    8'h37, 16, 8, 1, 0, 0, 0, 2'b11, -1, 32);
        send_frame("par_bad",   8'h37, 16, 8, 1, 0, 0, 1, 2'b11, -1, 32);
        send_frame("stop2_bad", 8'h15, 8,  5, 0, 0, 1, 0, 2'b01, -1, 16);
        send_frame("stop2_ok",  8'h0A, 8,  5, 0, 0, 1, 0, 2'b11, -1, 16);

        Prescale = 16;
        drive_level(1'b0, 2, dv);
        drive_level(1'b1, 48, dv2);
        check("glitch.dv_count", dv + dv2, 0);
        check("glitch.p_data",   rx_if.P_DATA,   exp_pdata);
        check("glitch.par_err",  rx_if.Par_err,  0);
        check("glitch.stop_err", rx_if.Stop_err, 0);

        send_frame("spike",  8'h5A, 16, 8, 0, 0, 0, 0, 2'b11, 3, 32);
        send_frame("b2b_1",  8'h12, 8,  8, 0, 0, 0, 0, 2'b11, -1, 0);
        send_frame("b2b_2",  8'h34, 8,  8, 0, 0, 0, 0, 2'b11, -1, 16);

        Prescale = 8; Data_len = 8; PAR_EN = 0; STOP2 = 0;
        drive_level(1'b0, 8, dv);
        drive_level(1'b1, 12, dv);
        #2 Reset = 1'b0;
        #1;
        check("rst_mid.p_data",     rx_if.P_DATA,     0);
        check("rst_mid.data_valid", rx_if.Data_valid, 0);
        check("rst_mid.par_err",    rx_if.Par_err,    0);
        check("rst_mid.stop_err",   rx_if.Stop_err,   0);
        exp_pdata = '0;
        @(negedge CLK); Reset = 1'b1;
        drive_level(1'b1, 16, dv);
        send_frame("after_rst", 8'h7E, 8, 8, 0, 0, 0, 0, 2'b11, -1, 16);

`ifdef UART_RX_BREAK_DET_EN
        send_frame("brk", 8'h00, 8, 8, 0, 0, 0, 0, 2'b00, -1, 0);
        drive_level(1'b0, 80, dv);
        drive_level(1'b1, 7, dv2);
        dv += dv2;
        drive_level(1'b0, 40, dv2);
        dv += dv2;
        check("brk_hold.dv_count", dv, 0);
        check("brk_hold.stop_err", rx_if.Stop_err, 1);
        drive_level(1'b1, 24, dv);
        send_frame("after_brk", 8'h3C, 8, 8, 0, 0, 0, 0, 2'b11, -1, 16);
`endif

        for (int k = 0; k < 24; k++) begin
            rd    = DW'($urandom);
            pres  = $urandom_range(0, 20);
            len   = $urandom_range(0, 15);
            pen   = 1'($urandom_range(0, 1));
            ptyp  = 1'($urandom_range(0, 1));
            s2    = 1'($urandom_range(0, 1));
            badp  = pen && ($urandom_range(0, 3) == 0);
            stops = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            sbit  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1;
            send_frame($sformatf("rnd%0d", k), rd, pres, len, pen, ptyp, s2, badp, stops, sbit, 48);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
